// File: rtl/bcd_sched_pkg.sv
// Shared definitions for the BCD conversion scheduler.
//   state_e    : scheduler FSM states (IDLE, ISSUE, WAIT, DELIVER)
//   BCD_MAX    : largest operand a four-digit BCD result can represent
//   BCD_ERR    : result word reported for an aborted conversion
//   CH_W       : width of a channel index (covers up to 8 channels)
//   clamp_bcd  : clamps an operand to BCD_MAX and reports whether it clamped
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    localparam logic [15:0] BCD_MAX = 16'd9999;
    localparam logic [15:0] BCD_ERR = 16'hFFFF;
    localparam int          CH_W    = 3;

    // Returns {sat, value}.
    function automatic logic [16:0] clamp_bcd(input logic [15:0] v);
        if (v > BCD_MAX) begin
            return {1'b1, BCD_MAX};
        end
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bcd_scheduler_arb.sv
// Combinational round-robin arbiter.
// Searches the request vector starting at (last_grant+1) mod NUM_CH and
// returns the first requesting channel.
//   req        : per-channel request bits
//   last_grant : channel served most recently
//   grant      : selected channel index (0 when no request)
//   any_req    : at least one request bit is high
module rr_arbiter
    import bcd_sched_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    // Walk distances from farthest to nearest; the nearest hit overwrites
    // the others, so the channel right after last_grant has top priority.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (req[j] && (j == ((int'(last_grant) + k) % NUM_CH))) begin
                    grant   = CH_W'(j);
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_scheduler.sv
// Schedules requests from NUM_CH channels onto one shared binary-to-BCD
// converter. One conversion is in flight at a time; channels are served
// round-robin and each delivered result is tagged with its channel.
//
// Optional feature: define BCD_SCHED_TIMEOUT_EN to abort a conversion that
// has not completed after TIMEOUT_CYCLES WAIT cycles (result 16'hFFFF with
// result_err set). Without it WAIT is unbounded and result_err is 0.
//
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-low reset
//   req, bin_in   : per-channel request level and 16-bit binary operand
//   ack           : one-cycle pulse to the served channel
//   conv_start    : one-cycle start pulse to the converter
//   conv_bin      : operand to the converter, held until the next grant
//   conv_done     : converter completion flag (rising edge completes)
//   conv_dec      : converter BCD result, valid while conv_done is high
//   dec_out       : last delivered BCD result
//   result_valid  : one-cycle pulse qualifying the result outputs
//   result_ch     : channel the delivered result belongs to
//   result_sat    : delivered operand was clamped to 9999
//   result_err    : delivered result is an aborted conversion
module bcd_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH*16-1:0] bin_in,
    output logic [NUM_CH-1:0]    ack,
    output logic                 conv_start,
    output logic [15:0]          conv_bin,
    input  logic                 conv_done,
    input  logic [15:0]          conv_dec,
    output logic [15:0]          dec_out,
    output logic                 result_valid,
    output logic [CH_W-1:0]      result_ch,
    output logic                 result_sat,
    output logic                 result_err
);

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("bcd_scheduler: illegal NUM_CH or TIMEOUT_CYCLES");
    end

    state_e              state_q;
    logic [CH_W-1:0]     last_grant_q;
    logic [CH_W-1:0]     grant_q;
    logic                sat_q;
    logic                done_prev_q;
    logic                conv_start_q;
    logic [15:0]         conv_bin_q;
    logic [NUM_CH-1:0]   ack_q;
    logic [15:0]         dec_out_q;
    logic                result_valid_q;
    logic [CH_W-1:0]     result_ch_q;
    logic                result_sat_q;

    logic [CH_W-1:0]     arb_grant;
    logic                arb_any;
    logic [15:0]         raw_bin;
    logic [15:0]         op_val_d;
    logic                op_sat_d;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    // Operand of the channel the arbiter would grant this cycle, clamped.
    always_comb begin
        raw_bin = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (CH_W'(j) == arb_grant) begin
                raw_bin = bin_in[16*j +: 16];
            end
        end
        {op_sat_d, op_val_d} = clamp_bcd(raw_bin);
    end

`ifdef BCD_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             result_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= CH_W'(NUM_CH - 1);
            grant_q        <= '0;
            sat_q          <= 1'b0;
            done_prev_q    <= 1'b0;
            conv_start_q   <= 1'b0;
            conv_bin_q     <= '0;
            ack_q          <= '0;
            dec_out_q      <= '0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_sat_q   <= 1'b0;
`ifdef BCD_SCHED_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            result_err_q   <= 1'b0;
`endif
        end else begin
            // Tracked every cycle so a level already high when WAIT is
            // entered is seen as "previously high" and cannot complete.
            done_prev_q    <= conv_done;
            conv_start_q   <= 1'b0;
            ack_q          <= '0;
            result_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_q      <= arb_grant;
                        conv_bin_q   <= op_val_d;
                        sat_q        <= op_sat_d;
                        conv_start_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
`ifdef BCD_SCHED_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (conv_done && !done_prev_q) begin
                        dec_out_q      <= conv_dec;
                        ack_q          <= NUM_CH'(1) << grant_q;
                        result_valid_q <= 1'b1;
                        result_ch_q    <= grant_q;
                        result_sat_q   <= sat_q;
`ifdef BCD_SCHED_TIMEOUT_EN
                        result_err_q   <= 1'b0;
`endif
                        state_q        <= ST_DELIVER;
                    end
`ifdef BCD_SCHED_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        dec_out_q      <= BCD_ERR;
                        ack_q          <= NUM_CH'(1) << grant_q;
                        result_valid_q <= 1'b1;
                        result_ch_q    <= grant_q;
                        result_sat_q   <= sat_q;
                        result_err_q   <= 1'b1;
                        state_q        <= ST_DELIVER;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end

                ST_DELIVER: begin
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign conv_start   = conv_start_q;
    assign conv_bin     = conv_bin_q;
    assign dec_out      = dec_out_q;
    assign result_valid = result_valid_q;
    assign result_ch    = result_ch_q;
    assign result_sat   = result_sat_q;
`ifdef BCD_SCHED_TIMEOUT_EN
    assign result_err   = result_err_q;
`else
    assign result_err   = 1'b0;
`endif

endmodule

// File: doc/bcd_scheduler.md
BCD_SCHEDULER -- requirements
Module: bcd_scheduler

Interface
REQ-001 Parameter NUM_CH, default 3: number of requesting channels; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT-state cycles before abort, used only when the timeout macro is defined.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous and active-low.
REQ-005 Port req, input, NUM_CH: per-channel conversion request; level, held until the matching ack.
REQ-006 Port bin_in, input, NUM_CH*16: per-channel binary value; channel i occupies bits [16i+15:16i].
REQ-007 Port ack, output, NUM_CH: one-cycle pulse to the served channel.
REQ-008 Port conv_start, output, 1: one-cycle start pulse to the shared BCD converter.
REQ-009 Port conv_bin, output, 16: operand to the converter; held stable from the start pulse until the result is taken.
REQ-010 Port conv_done, input, 1: converter completion flag; may be held high for more than one cycle.
REQ-011 Port conv_dec, input, 16: converter BCD result; valid while conv_done is high.
REQ-012 Port dec_out, output, 16: last delivered four-digit BCD result.
REQ-013 Port result_valid, output, 1: one-cycle pulse qualifying dec_out, result_ch and result_err.
REQ-014 Port result_ch, output, 3: index of the channel the delivered result belongs to.
REQ-015 Port result_sat, output, 1: delivered operand was clamped.
REQ-016 Port result_err, output, 1: delivered result is an aborted conversion.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and DELIVER.
REQ-018 IDLE: if any req bit is high, grant round-robin starting at (last_grant+1) mod NUM_CH, latch the operand, and go to ISSUE; otherwise stay in IDLE.
REQ-019 Operand latch: value > 9999 SHALL be clamped to 9999 (16'h270F) with the sat flag set; otherwise pass unchanged.
REQ-020 ISSUE: conv_start high for exactly this cycle, conv_bin equal to the latched operand; go to WAIT.
REQ-021 WAIT: the completion condition is conv_done high AND conv_done low the previous cycle (rising edge); a level already high on entry SHALL NOT complete the wait.
REQ-022 On completion, capture conv_dec into dec_out and go to DELIVER.
REQ-023 DELIVER: result_valid and ack[granted] high for exactly this cycle; last_grant updated; go to IDLE.
REQ-024 Latency: req sampled in IDLE at edge k → conv_start at k+1; valid conv_done edge at edge m → result_valid at m+1.
REQ-025 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the conversion, and its ack is still issued.
REQ-026 Changes on bin_in after the latch SHALL NOT affect conv_bin.
REQ-027 Simultaneous requests SHALL be served in strict rotation, with no channel starved beyond NUM_CH-1 services.
REQ-028 dec_out, result_ch and result_sat SHALL hold their values between result_valid pulses.

Reset
REQ-029 rst low at a clock edge SHALL force IDLE from any state, including mid-WAIT; the in-flight conversion is discarded and no ack is issued.
REQ-030 Reset values: ack=0, conv_start=0, conv_bin=0, dec_out=0, result_valid=0, result_ch=0, result_sat=0, result_err=0, last_grant=NUM_CH-1 (so channel 0 wins first).

Configuration
REQ-031 Macro BCD_SCHED_TIMEOUT_EN defined: a WAIT cycle counter aborts the conversion after TIMEOUT_CYCLES cycles without completion, going to DELIVER with dec_out=16'hFFFF and result_err=1.
REQ-032 Macro undefined: WAIT has no bound, the counter is absent, and result_err is tied 0.

Structure
REQ-033 Package bcd_sched_pkg SHALL hold the state enum, BCD_MAX=16'd9999, BCD_ERR=16'hFFFF and the channel-index width.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_grant; outputs grant index and any_req); it is purely combinational.

Verification
REQ-035 Bench SHALL cover: req=3'b001, bin_in ch0=1234, converter model responds after 30 cycles with 16'h1234 → conv_start at k+1, result_valid with dec_out=16'h1234, result_ch=0, ack[0] pulse.
REQ-036 Bench SHALL cover: req=3'b111 held → grants in order 0,1,2,0, each with exactly one ack.
REQ-037 Bench SHALL cover: ch1 bin_in=12000 → conv_bin=16'h270F, result_sat=1.
REQ-038 Bench SHALL cover: conv_done stuck high on entry to WAIT → no completion until a low-then-high transition.
REQ-039 Bench SHALL cover, with the macro defined and TIMEOUT_CYCLES=64: no conv_done → result_valid 65 cycles after conv_start, dec_out=16'hFFFF, result_err=1.
REQ-040 Bench SHALL cover: rst low during WAIT → next cycle all outputs at reset values, no ack, and channel 0 is granted first afterwards.
